// File: rtl/bytecode_fetch.sv
`default_nettype none
// ============================================================================
// bytecode_fetch : byte prefetch queue between program memory and the core
// Revision 1.0 - initial release
// ============================================================================
module bytecode_fetch #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    output logic [7:0] op_code,
    output logic [7:0] arg0,
    output logic [7:0] arg1,
    output logic [2:0] avail,
    input  logic [1:0] argc,
    output logic       op_ready,
    input  logic       op_done,
    input  logic       jump,
    input  logic [7:0] jump_target,
    output logic [7:0] program_counter
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [7:0]    q_q [DEPTH];
    logic [7:0]    q_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fetch_addr_q, fetch_addr_d;
    logic [7:0]    pc_q, pc_d;
    logic [7:0]    mem_addr_q, mem_addr_d;
    logic          inflight_q, inflight_d;
    logic          drop_q, drop_d;
    logic          mem_rd_q, mem_rd_d;

    logic [CW-1:0] w_need;
    logic          w_fill, w_consume, w_issue;
    logic [AW-1:0] w_idx1, w_idx2;

    assign w_need    = CW'(argc) + CW'(1);
    assign op_ready  = (count_q >= w_need);
    assign w_consume = op_done & op_ready;
    assign w_fill    = inflight_q & ~drop_q;
    // Reserve a slot for the read already in flight so the queue never overflows.
    assign w_issue   = ((count_q + CW'(inflight_q)) < C_DEPTH) & ~jump;

    always_comb begin
        q_d          = q_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        drop_d       = 1'b0;
        inflight_d   = w_issue;
        mem_rd_d     = w_issue;
        mem_addr_d   = w_issue ? fetch_addr_q : mem_addr_q;

        if (jump) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            pc_d         = jump_target;
            fetch_addr_d = jump_target;
            drop_d       = inflight_q;
        end else begin
            if (w_fill) begin
                q_d[tail_q] = mem_data;
                tail_d      = tail_q + AW'(1);
            end
            if (w_consume) begin
                head_d = head_q + w_need[AW-1:0];
                pc_d   = pc_q + 8'(w_need);
            end
            count_d = count_q + CW'(w_fill) - (w_consume ? w_need : '0);
            if (w_issue) begin
                fetch_addr_d = fetch_addr_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= 8'h00;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pc_q         <= 8'h00;
            fetch_addr_q <= 8'h00;
            mem_addr_q   <= 8'h00;
            inflight_q   <= 1'b0;
            drop_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
        end else begin
            q_q          <= q_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            mem_rd_q     <= mem_rd_d;
        end
    end

    assign w_idx1          = head_q + AW'(1);
    assign w_idx2          = head_q + AW'(2);
    assign op_code         = q_q[head_q];
    assign arg0            = q_q[w_idx1];
    assign arg1            = q_q[w_idx2];
    assign avail           = 3'(count_q);
    assign program_counter = pc_q;
    assign mem_addr        = mem_addr_q;
    assign mem_rd          = mem_rd_q;

endmodule
`default_nettype wire

// File: doc/bytecode_fetch.md
# bytecode_fetch

Instruction fetch unit feeding the `cpu` core. It streams bytes from a synchronous program memory into a small prefetch queue. The current opcode and its two following argument bytes are presented to the core, and the queue head advances by `1 + argc` bytes when the core signals `op_done`. It also owns the architectural program counter and handles jump redirects by flushing the queue.

## Interface
- `DEPTH`, default 4: prefetch queue depth in bytes. Must be a power of 2 and at least 4.
- `clk` in 1: single clock. All state updates on the posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_addr` out 8: program memory read address. Registered.
- `mem_rd` out 1: read strobe. Registered.
- `mem_data` in 8: read data. Valid in the cycle after `mem_rd`=1; sampled at the following posedge.
- `op_code` out 8: byte at queue head.
- `arg0` out 8: byte at head+1.
- `arg1` out 8: byte at head+2.
- `avail` out 3: number of valid bytes in the queue, 0..DEPTH.
- `argc` in 2: argument count of the current opcode, from the control unit. Legal values 0..2.
- `op_ready` out 1: combinational, `avail >= 1 + argc`.
- `op_done` in 1: core has finished the current instruction; consume `1 + argc` bytes.
- `jump` in 1: redirect fetch.
- `jump_target` in 8: new program counter, sampled when `jump`=1.
- `program_counter` out 8: address of the byte at queue head.

## Operation
- **State**
  - Queue storage `q[DEPTH]`, `head` and `tail` pointers, `count`.
  - `fetch_addr` (8b).
  - `inflight` (1b): a read was issued last cycle.
  - `drop` (1b): discard the returning read.
  - `pc` (8b).
- **Issue**
  - Assert `mem_rd` with `mem_addr = fetch_addr` when `count + inflight < DEPTH` and `jump`=0.
  - On issue, `fetch_addr` increments by 1. It is 8-bit and wraps from 0xFF to 0x00.
  - At most one read is issued per cycle.
- **Fill**
  - If `inflight`=1 and `drop`=0, `mem_data` is written at `q[tail]`, `tail` increments, and `count` increments.
- **Consume**
  - When `op_done`=1 and `op_ready`=1: `head += 1 + argc`, `count -= 1 + argc`, `pc += 1 + argc` (mod 256).
  - `op_done` while `op_ready`=0 is ignored: no state change.
  - Fill and consume in the same cycle both apply: `count_next = count + fill - consumed`.
- **Jump** (priority over `op_done` and fill)
  - `head = tail = count = 0`.
  - `pc = fetch_addr = jump_target`.
  - `mem_rd`=0 this cycle.
  - If a read is in flight, `drop`=1 so it is discarded on return.
  - Issue resumes next cycle from `jump_target`.
- **Outputs**
  - `op_code`, `arg0`, `arg1` are combinational reads of `q[head]`, `q[head+1]`, `q[head+2]`, with pointer arithmetic mod DEPTH.
  - Content beyond `avail` is stale and not meaningful.
- **Reset** (asynchronous, `rst_n`=0)
  - `pc`, `fetch_addr`, `head`, `tail`, `count` = 0.
  - `inflight`, `drop`, `mem_rd` = 0; `mem_addr` = 0x00.
  - All `q` entries = 0x00, so `op_code`, `arg0`, `arg1` = 0x00, `avail` = 0, `program_counter` = 0x00.
  - Reset mid-operation discards queue contents and any in-flight read. The returning data is not written, because `inflight` is cleared.

## Timing
- **Startup.** E1 is the first posedge with `rst_n`=1.
  - E1: `mem_rd`=1, `mem_addr`=0x00.
  - E2: byte 0 captured, `avail`=1, read of 0x01 issued.
  - Sustained rate is 1 byte per cycle while not full.
  - `op_ready` for `argc`=0 after E2; for `argc`=2 after E4.
- **Consume latency.** Outputs reflect the new head on the posedge after an accepted `op_done`.
- **Full.** With no consumption, `count` saturates at DEPTH and `mem_rd` stays 0. Issue resumes the cycle after a consume frees space.
- **Jump latency.**
  - Jump sampled at posedge Ej: read of `jump_target` issued at Ej+1, first byte valid (`avail`=1) at Ej+2.
  - `program_counter` = `jump_target` from Ej.

## Test plan
- **Reset and fill.** Memory holds byte i at address i; release `rst_n`, no `op_done` → `mem_addr` 0x00, 0x01, 0x02, 0x03 on consecutive cycles; `avail` reaches 4; `mem_rd`=0 thereafter; `op_code`=0x00, `arg0`=0x01, `arg1`=0x02.
- **Mixed consume.**
  - Steady stream with `op_done` pulsed at `argc` = 0, 2, 1 → `program_counter` 0→1→4→6; `op_code` 0x01 then 0x04 then 0x06.
  - `op_done` with `argc`=2 while `avail`=2 → ignored, `pc` unchanged.
- **Jump flush.** Jump to 0x40 while a read is in flight → returning byte discarded; `avail`=0 for two cycles; then `op_code`=0x40 and `program_counter`=0x40.
- **Jump + op_done same cycle.** Jump wins; `pc`=`jump_target`, not `pc+1+argc`.
- **Wrap.** Jump to 0xFE and consume 1-byte ops → `mem_addr` sequence 0xFE, 0xFF, 0x00; `program_counter` wraps 0xFF→0x00; `arg0`/`arg1` straddling the wrap read 0xFF, 0x00 correctly.
- **Reset mid-operation.** Assert `rst_n`=0 with `avail`=3 and a read in flight → all outputs 0 immediately (asynchronous); after release, fetch restarts at 0x00 and no stale byte appears.
